// File: rtl/mbist_pkg.sv
// mbist_pkg: shared FSM encoding and March C- element tables, indexed by element number.
package mbist_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, RD, WR, DRAIN, DONE} state_t;
    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;
    localparam logic [7:0] EL_DOWN  = (8'd1 << E3) | (8'd1 << E4);
    localparam logic [7:0] EL_RPAT  = (8'd1 << E2) | (8'd1 << E4);
    localparam logic [7:0] EL_WPAT  = (8'd1 << E1) | (8'd1 << E3);
    localparam logic [7:0] EL_HASRD = (8'd1 << E1) | (8'd1 << E2) | (8'd1 << E3) | (8'd1 << E4) | (8'd1 << E5);
    localparam logic [7:0] EL_HASWR = (8'd1 << E0) | (8'd1 << E1) | (8'd1 << E2) | (8'd1 << E3) | (8'd1 << E4);
endpackage

// File: rtl/mbist_rd_cmp.sv
// mbist_rd_cmp: 2-stage expected-data pipeline matching read latency, plus comparator.
// With MBIST_DIAG_EN it also records the first mismatch and a saturating error count.
module mbist_rd_cmp import mbist_pkg::*; #(
    parameter int DATA_WIDTH = 8
`ifdef MBIST_DIAG_EN
    , parameter int ADDR_WIDTH = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  rd_en,
    input  logic                  exp_bit,
`ifdef MBIST_DIAG_EN
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            err_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  mismatch
);
    logic [1:0] vld, exp;
    assign mismatch = vld[1] && (rdata != {DATA_WIDTH{exp[1]}});
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            exp <= '0;
        end else begin
            vld <= flush ? 2'b00 : {vld[0], rd_en};
            exp <= {exp[0], exp_bit};
        end
    end
`ifdef MBIST_DIAG_EN
    logic [ADDR_WIDTH-1:0] a1, a2;
    logic [2:0] m1, m2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a1, a2, m1, m2} <= '0;
            {fail_addr, fail_elem, fail_data, err_cnt} <= '0;
        end else begin
            {a1, a2, m1, m2} <= {addr, a1, elem, m1};
            if (flush) begin
                {fail_addr, fail_elem, fail_data, err_cnt} <= '0;
            end else if (mismatch) begin
                if (err_cnt == 8'd0) {fail_addr, fail_elem, fail_data} <= {a2, m2, rdata};
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST sequencer.
// MBIST_DIAG_EN adds first-failure diagnostics and runs to completion; otherwise the first mismatch ends the test.
module mbist_march_ctrl import mbist_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  write_read,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
`ifdef MBIST_DIAG_EN
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            err_cnt,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  fail
);
    state_t state, state_n;
    logic [2:0] elem, elem_n, elem_nx;
    logic [ADDR_WIDTH-1:0] addr_n, step;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic fail_n, drain, drain_n, last, accept, mismatch;

    assign write_read = state == WR;
    assign busy = state inside {SETUP, RD, WR, DRAIN};
    assign done = state == DONE;
    assign accept = start && (state == IDLE || state == DONE);

    always_comb begin
        state_n = state;
        elem_n = elem;
        addr_n = address;
        wdata_n = wdata;
        drain_n = 1'b1;
        fail_n = fail | mismatch;
        elem_nx = elem + 3'd1;
        last = EL_DOWN[elem] ? address == '0 : address == '1;
        step = EL_DOWN[elem] ? address - ADDR_WIDTH'(1) : address + ADDR_WIDTH'(1);
        case (state)
            IDLE, DONE: if (accept) begin
                state_n = SETUP;
                elem_n = E0;
                addr_n = '0;
                wdata_n = {DATA_WIDTH{EL_WPAT[E0]}};
                fail_n = 1'b0;
            end
            SETUP: state_n = EL_HASRD[elem] ? RD : WR;
            RD: begin
                drain_n = 1'b0;
                state_n = EL_HASWR[elem] ? WR : last ? DRAIN : RD;
                addr_n = (EL_HASWR[elem] || last) ? address : step;
            end
            WR: if (last) begin
                state_n = SETUP;
                elem_n = elem_nx;
                addr_n = EL_DOWN[elem_nx] ? '1 : '0;
                wdata_n = {DATA_WIDTH{EL_WPAT[elem_nx]}};
            end else begin
                state_n = EL_HASRD[elem] ? RD : WR;
                addr_n = step;
            end
            DRAIN: state_n = drain ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
`ifndef MBIST_DIAG_EN
        if (mismatch && busy) state_n = DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            elem <= E0;
            address <= '0;
            wdata <= '0;
            fail <= 1'b0;
            drain <= 1'b0;
        end else begin
            state <= state_n;
            elem <= elem_n;
            address <= addr_n;
            wdata <= wdata_n;
            fail <= fail_n;
            drain <= drain_n;
        end
    end

    mbist_rd_cmp #(
        .DATA_WIDTH(DATA_WIDTH)
`ifdef MBIST_DIAG_EN
        , .ADDR_WIDTH(ADDR_WIDTH)
`endif
    ) u_cmp (
        .clk(clk),
        .rst_n(rst_n),
        .flush(accept),
        .rd_en(state == RD),
        .exp_bit(EL_RPAT[elem]),
`ifdef MBIST_DIAG_EN
        .addr(address),
        .elem(elem),
        .fail_addr(fail_addr),
        .fail_elem(fail_elem),
        .fail_data(fail_data),
        .err_cnt(err_cnt),
`endif
        .rdata(rdata),
        .mismatch(mismatch)
    );
endmodule

// File: doc/mbist_march_ctrl.md
MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; test covers addresses 0 .. 2^ADDR_WIDTH-1 (N words).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request, sampled only in IDLE or DONE.
REQ-006 SHALL have port write_read, output, 1 bit: 1 = write, 0 = read, driven to the memory.
REQ-007 SHALL have port address, output, ADDR_WIDTH bits: memory address.
REQ-008 SHALL have port wdata, output, DATA_WIDTH bits: write data.
REQ-009 SHALL have port rdata, input, DATA_WIDTH bits: memory read data.
REQ-010 SHALL have ports busy, done and fail, outputs, 1 bit each: test running, test finished (level, held until next start), mismatch seen (sticky).

Function
REQ-011 SHALL run March C- with the following elements:
- E0 up(w0)
- E1 up(r0,w1)
- E2 up(r1,w0)
- E3 down(r0,w1)
- E4 down(r1,w0)
- E5 up(r0)
- Background 0 = all-zeros, 1 = all-ones.
REQ-012 SHALL use states IDLE, SETUP, RD, WR, DRAIN, DONE; transitions:
- IDLE/DONE -start-> SETUP(E0).
- SETUP -> WR (E0) or RD (E1-E5).
- RD -> WR (E1-E4) or next address RD (E5).
- WR -> RD/WR at next address, or SETUP of the next element after the last address.
- Last read of E5 -> DRAIN; DRAIN lasts 2 cycles, then goes to DONE.
REQ-013 SHALL spend exactly one SETUP cycle per element, with write_read=0, address = first address of the element, and wdata = the element's write pattern.
REQ-014 SHALL drive wdata one cycle ahead of each write, because the memory registers wdata internally; wdata SHALL hold the element pattern for the whole element.
REQ-015 SHALL treat read data as valid exactly 2 cycles after a read cycle; expected value and address SHALL travel in a 2-stage valid pipeline and be compared on arrival.
REQ-016 SHALL set fail on any compare mismatch; fail stays set until the next start.
REQ-017 SHALL hold busy high for exactly 10*N+8 cycles (168 for ADDR_WIDTH=4), starting the cycle after start is sampled; done SHALL rise on the cycle busy falls.
REQ-018 SHALL step up-elements through addresses 0 to N-1 and down-elements through N-1 to 0; address counter wrap SHALL NOT spill into another element.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL clear fail and done on the cycle start is accepted.
REQ-021 SHALL drive write_read=0 in IDLE, DRAIN and DONE.

Reset
REQ-022 On rst_n low, SHALL asynchronously force: state IDLE, write_read=0, address=0, wdata=0, busy=0, done=0, fail=0, compare pipeline invalid.
REQ-023 Reset mid-test SHALL abort the test with no further writes; a new start is required afterwards.

Configuration
REQ-024 Macro MBIST_DIAG_EN, when defined, SHALL add the following outputs:
- fail_addr (ADDR_WIDTH bits): address of the first mismatch.
- fail_elem (3 bits): element of the first mismatch.
- fail_data (DATA_WIDTH bits): read data of the first mismatch.
- err_cnt (8 bits, saturating at 255): number of mismatches.
With MBIST_DIAG_EN defined, the test SHALL run to completion.
REQ-025 Without MBIST_DIAG_EN, those ports SHALL be absent, and the first mismatch SHALL end the test: state goes to DONE with fail=1 and done=1.

Structure
REQ-026 Shared package mbist_pkg SHALL hold the state enum, the element-index constants E0-E5, and the per-element tables (direction, read pattern, write pattern, has-read, has-write).
REQ-027 Sub-module mbist_rd_cmp SHALL implement the 2-stage expected-data pipeline and the comparator.

Verification
REQ-028 Fault-free memory model, start pulse -> busy for 168 cycles, then done=1 and fail=0.
REQ-029 Stuck-at-0 on bit 3 at address 5 -> fail=1; with diag: fail_addr=5, fail_elem=2, fail_data=8'hF7.
REQ-030 Coupling fault as in fault_mem (bit 5 of address 6 keeps its old value when the bit-5/bit-6/bit-4 neighbour pattern matches) -> fail=1.
REQ-031 Reset asserted at cycle 50 of a test -> all outputs return to their reset values immediately; a new start then completes normally in 168 cycles.
REQ-032 Start pulsed at cycle 20 of a test -> ignored; done still rises at cycle 168.
REQ-033 Without MBIST_DIAG_EN, stuck-at-1 at address 0 -> done within 2 cycles of E1's first read returning, fail=1.
